// File: rtl/vga_text_writer.sv
// rtl/vga_text_writer.sv - byte stream to VGA text buffer writer with 80x30 cursor
// Optional screen clear on 0x0C is built when VGA_TEXT_WRITER_CLEAR_EN is defined.
module vga_text_writer #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 12,
  parameter int WR_HOLD          = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    rx_data_i,
  input  logic                          rx_valid_i,
  output logic                          rx_ready_o,
  output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
  output logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
  output logic                          axil_wready_o,
  output logic [6:0]                    cursor_col_o,
  output logic [4:0]                    cursor_row_o,
  output logic                          busy_o
);

  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam int HOLD_W = (WR_HOLD > 2) ? $clog2(WR_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WR_HOLD - 1);

  localparam logic [6:0] LAST_COL = 7'd79;
  localparam logic [4:0] LAST_ROW = 5'd29;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

`ifdef VGA_TEXT_WRITER_CLEAR_EN
  localparam logic [7:0] CH_FF     = 8'h0C;
  localparam logic [9:0] LAST_WORD = 10'd599;
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
`ifdef VGA_TEXT_WRITER_CLEAR_EN
  logic [9:0]        word_cnt;
`endif

  logic       printable;
  logic [6:0] adv_col;
  logic [4:0] adv_row;
  logic [4:0] lf_row;
  logic [6:0] bs_col;
  logic [11:0] cur_pos;
  logic [11:0] bs_pos;

  // Linear character index for a cursor position: row*80 + col, at most 2399.
  function automatic logic [11:0] pos_of(input logic [6:0] col, input logic [4:0] row);
    return (12'(row) * 12'd80) + 12'(col);
  endfunction

  // Next cursor positions for each kind of byte, plus the write positions they use.
  always_comb begin
    printable = (rx_data_i >= CH_SPACE) && (rx_data_i <= CH_TILDE);
    lf_row    = (cursor_row_o == LAST_ROW) ? 5'd0 : cursor_row_o + 5'd1;
    adv_col   = cursor_col_o + 7'd1;
    adv_row   = cursor_row_o;
    if (cursor_col_o == LAST_COL) begin
      adv_col = 7'd0;
      adv_row = lf_row;
    end
    bs_col  = cursor_col_o - 7'd1;
    cur_pos = pos_of(cursor_col_o, cursor_row_o);
    bs_pos  = pos_of(bs_col, cursor_row_o);
  end

  // Byte acceptance only happens in IDLE; reset masks it combinationally.
  assign rx_ready_o = (state == IDLE) && !rst_i;
  assign busy_o     = (state != IDLE);

  // Control FSM: interprets accepted bytes, moves the cursor and drives buffer writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      axil_wready_o <= 1'b0;
      axil_wdata_o  <= '0;
      axil_wstrb_o  <= '0;
      axil_waddr_o  <= '0;
      cursor_col_o  <= '0;
      cursor_row_o  <= '0;
`ifdef VGA_TEXT_WRITER_CLEAR_EN
      word_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid_i) begin
            if (printable) begin
              axil_waddr_o  <= C_AXI_ADDR_WIDTH'({cur_pos[11:2], 2'b00});
              axil_wstrb_o  <= STRB_W'(1) << cur_pos[1:0];
              axil_wdata_o  <= C_AXI_DATA_WIDTH'({4{rx_data_i}});
              axil_wready_o <= 1'b1;
              hold_cnt      <= '0;
              state         <= WRITE;
              cursor_col_o  <= adv_col;
              cursor_row_o  <= adv_row;
            end else if (rx_data_i == CH_BS) begin
              // Backspace erases the cell to the left; it never crosses a line start.
              if (cursor_col_o != 7'd0) begin
                axil_waddr_o  <= C_AXI_ADDR_WIDTH'({bs_pos[11:2], 2'b00});
                axil_wstrb_o  <= STRB_W'(1) << bs_pos[1:0];
                axil_wdata_o  <= C_AXI_DATA_WIDTH'({4{CH_SPACE}});
                axil_wready_o <= 1'b1;
                hold_cnt      <= '0;
                state         <= WRITE;
                cursor_col_o  <= bs_col;
              end
            end else if (rx_data_i == CH_CR) begin
              cursor_col_o <= 7'd0;
            end else if (rx_data_i == CH_LF) begin
              cursor_col_o <= 7'd0;
              cursor_row_o <= lf_row;
`ifdef VGA_TEXT_WRITER_CLEAR_EN
            end else if (rx_data_i == CH_FF) begin
              axil_waddr_o  <= '0;
              axil_wstrb_o  <= '1;
              axil_wdata_o  <= C_AXI_DATA_WIDTH'({4{CH_SPACE}});
              axil_wready_o <= 1'b1;
              hold_cnt      <= '0;
              word_cnt      <= '0;
              state         <= CLEAR;
`endif
            end
          end
        end

        WRITE: begin
          if (hold_cnt == HOLD_LAST) begin
            axil_wready_o <= 1'b0;
            state         <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

`ifdef VGA_TEXT_WRITER_CLEAR_EN
        CLEAR: begin
          // Words go out back to back; only the address changes between them.
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            if (word_cnt == LAST_WORD) begin
              axil_wready_o <= 1'b0;
              cursor_col_o  <= 7'd0;
              cursor_row_o  <= 5'd0;
              state         <= IDLE;
            end else begin
              word_cnt     <= word_cnt + 10'd1;
              axil_waddr_o <= axil_waddr_o + C_AXI_ADDR_WIDTH'(4);
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
`endif

        default: begin
          axil_wready_o <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// tb/tb_vga_text_writer.sv - scoreboard bench for vga_text_writer with a cursor-level model
module tb_vga_text_writer;

  localparam int WR_HOLD = 2;
  localparam int BOUND   = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [11:0] waddr;
  logic        wready;
  logic [6:0]  col;
  logic [4:0]  row;
  logic        busy;

  vga_text_writer #(
    .C_AXI_DATA_WIDTH(32),
    .C_AXI_ADDR_WIDTH(12),
    .WR_HOLD(WR_HOLD)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_data_i(rx_data),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready),
    .axil_wdata_o(wdata),
    .axil_wstrb_o(wstrb),
    .axil_waddr_o(waddr),
    .axil_wready_o(wready),
    .cursor_col_o(col),
    .cursor_row_o(row),
    .busy_o(busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t cur;
  int  checks = 0;
  int  errors = 0;
  int  m_col = 0;
  int  m_row = 0;
  int  grp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  function automatic void push_write(input int pos, input logic [7:0] b);
    wr_t w;
    w.addr = 12'((pos / 4) * 4);
    w.strb = 4'(1 << (pos % 4));
    w.data = {4{b}};
    exp_q.push_back(w);
  endfunction

  // Screen-level model: returns the number of buffer writes the byte causes.
  function automatic int model_byte(input logic [7:0] b);
    int pos;
    pos = m_row * 80 + m_col;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_write(pos, b);
      pos = (pos + 1) % 2400;
      m_col = pos % 80;
      m_row = pos / 80;
      return 1;
    end
    if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col = m_col - 1;
        push_write(m_row * 80 + m_col, 8'h20);
        return 1;
      end
      return 0;
    end
    if (b == 8'h0D) begin
      m_col = 0;
      return 0;
    end
    if (b == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % 30;
      return 0;
    end
`ifdef VGA_TEXT_WRITER_CLEAR_EN
    if (b == 8'h0C) begin
      for (int a = 0; a < 600; a++) begin
        wr_t w;
        w.addr = 12'(a * 4);
        w.strb = 4'hF;
        w.data = 32'h20202020;
        exp_q.push_back(w);
      end
      m_col = 0;
      m_row = 0;
      return 600;
    end
`endif
    return 0;
  endfunction

  // Offer a byte, hold it until accepted, then check cursor and optionally the busy window.
  task automatic send_byte(input logic [7:0] b, input bit chk_lat);
    int n;
    int nw;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < BOUND) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= BOUND) begin
      fail_now("accept_wait");
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    nw = model_byte(b);
    #1;
    rx_valid = 1'b0;
    if (!(nw == 600)) begin
      chk("cursor_col", col, m_col);
      chk("cursor_row", row, m_row);
    end
    if (chk_lat) begin
      chk("busy_after_accept", busy, nw != 0);
      n = 0;
      while (!rx_ready && n < BOUND) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("ready_latency", n, nw * WR_HOLD);
      chk("cursor_col_idle", col, m_col);
      chk("cursor_row_idle", row, m_row);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!rx_ready && n < BOUND) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= BOUND) fail_now("idle_wait");
  endtask

  task automatic reset_now();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_wready", wready, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_ready", rx_ready, 0);
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", rx_ready, 1);
  endtask

  // Monitor: every WR_HOLD consecutive wready cycles form one write, compared to the queue head.
  always @(negedge clk) begin
    if (rst) begin
      grp = 0;
    end else if (wready) begin
      if (grp == 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h/%0h/%0h required=none", waddr, wstrb, wdata);
          cur.addr = waddr;
          cur.strb = wstrb;
          cur.data = wdata;
        end else begin
          cur = exp_q.pop_front();
          chk("wr_addr", waddr, cur.addr);
          chk("wr_strb", wstrb, cur.strb);
          chk("wr_data", wdata, cur.data);
        end
      end else begin
        chk("wr_hold_stable", {waddr, wstrb, wdata}, {cur.addr, cur.strb, cur.data});
      end
      grp++;
      if (grp == WR_HOLD) grp = 0;
    end else if (grp != 0) begin
      checks++;
      errors++;
      $display("FAIL write_hold actual=%0d required=%0d", grp, WR_HOLD);
      grp = 0;
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", rx_ready, 0);
    chk("reset_wready", wready, 0);
    chk("reset_wdata", wdata, 0);
    chk("reset_wstrb", wstrb, 0);
    chk("reset_waddr", waddr, 0);
    chk("reset_col", col, 0);
    chk("reset_row", row, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", rx_ready, 1);

    // First character at the origin.
    send_byte(8'h41, 1'b1);
    chk("a_col", col, 1);
    chk("a_row", row, 0);

    // Line wrap from (79,2).
    send_byte(8'h0D, 1'b0);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0A, 1'b0);
    for (int i = 0; i < 79; i++) send_byte(8'($urandom_range(32, 126)), 1'b0);
    send_byte(8'h5A, 1'b1);
    chk("linewrap_col", col, 0);
    chk("linewrap_row", row, 3);

    // Screen wrap from (79,29).
    while (m_row != 29) send_byte(8'h0A, 1'b0);
    for (int i = 0; i < 79; i++) send_byte(8'($urandom_range(32, 126)), 1'b0);
    send_byte(8'h78, 1'b1);
    chk("screenwrap_col", col, 0);
    chk("screenwrap_row", row, 0);

    // Control codes from (5,3).
    for (int i = 0; i < 3; i++) send_byte(8'h0A, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'h2E, 1'b0);
    send_byte(8'h08, 1'b1);
    chk("bs_col", col, 4);
    chk("bs_row", row, 3);
    send_byte(8'h0D, 1'b1);
    chk("cr_col", col, 0);
    chk("cr_row", row, 3);
    send_byte(8'h0A, 1'b1);
    chk("lf_col", col, 0);
    chk("lf_row", row, 4);
    send_byte(8'h08, 1'b1);
    chk("bs0_col", col, 0);

    // Form feed: full clear when built in, otherwise ignored.
    send_byte(8'h0C, 1'b1);

    // Backpressure: 'B' is held while the 'A' write is in progress.
    send_byte(8'h41, 1'b0);
    chk("bp_ready_low", rx_ready, 0);
    send_byte(8'h42, 1'b0);
    wait_idle();

    // Randomized byte stream.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        6:       send_byte(8'h08, 1'($urandom_range(0, 1)));
        7:       send_byte(8'h0D, 1'($urandom_range(0, 1)));
        8:       send_byte(8'h0A, 1'($urandom_range(0, 1)));
        9:       send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        default: send_byte(8'($urandom_range(32, 126)), 1'($urandom_range(0, 1)));
      endcase
    end
    wait_idle();

    // Reset in the middle of a character write.
    send_byte(8'h43, 1'b0);
    reset_now();

`ifdef VGA_TEXT_WRITER_CLEAR_EN
    // Reset in the middle of a clear.
    send_byte(8'h0C, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    reset_now();
`endif

    send_byte(8'h44, 1'b1);
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
